fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer between the program counter and the instruction memory port of the RV32 core. It samples the current PC, runs a request/acknowledge read on the instruction bus, and holds the returned word behind a valid/ready handshake to decode. It drives the PC write enable: it advances the PC when decode accepts an instruction, and loads the PC when the execute stage redirects. It also discards in-flight fetches on a redirect and reports bus timeouts.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: value of `instr` at reset and after a flush (addi x0,x0,0).
- `TIMEOUT`, default `255`: maximum REQ cycles without `mem_ack` before a fault is raised; `0` disables the timeout.

Ports:
- `clock`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  32  current PC value from the program counter.
- `pc_en`  out  1  PC write enable.
- `flush`  in  1  redirect from execute; the new target is loaded into the PC on this edge.
- `mem_req`  out  1  instruction bus read request.
- `mem_addr`  out  32  word address of the read; bits [1:0] are always 0.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  `instr` is valid for decode.
- `instr_ready`  in  1  decode accepts `instr`.
- `bus_fault`  out  1  sticky flag: the fetch timed out.
- `misalign`  out  1  sticky flag: the PC was misaligned (compiled in only with the configuration macro).

## Operation
- Reset values:
  - `mem_req`, `instr_valid`, `bus_fault`, `misalign`: 0.
  - `mem_addr`, `instr_pc`: 0.
  - `instr`: `NOP_INSTR`.
  - State: IDLE.
  - `pc_en` is forced to 0 while `reset` is low.
- `pc_en` is combinational: `pc_en = flush | (instr_valid & instr_ready)`.
- States:
  - **IDLE:** latch `mem_addr = {pc[31:2],2'b00}`, then go to REQ.
  - **REQ:** `mem_req` = 1 and `mem_addr` stays stable.
    - On `mem_ack`, capture `mem_rdata` and `instr_pc`, then go to HOLD.
    - If the discard flag is set, drop the data and go to IDLE instead.
  - **HOLD:** `instr_valid` = 1, and `instr` and `instr_pc` stay stable.
    - On `instr_ready`, go to IDLE.
  - **FAULT:** `mem_req` = 0 and `instr_valid` = 0. The block stays here until `flush`.
- Bus rule: once `mem_req` rises, it stays high until `mem_ack`. The only exception is a timeout abort.
- `flush`, by state:
  - In HOLD: `instr_valid` drops next cycle, `instr` becomes `NOP_INSTR`, and the state goes to IDLE.
  - In REQ: a discard flag is set, `mem_req` stays high until ack, the data is dropped, and the state goes to IDLE.
  - In IDLE: the block returns to IDLE. It re-latches `mem_addr` from `pc` on the cycle after the flush edge.
  - In FAULT: clear `bus_fault` and `misalign`, go to IDLE.
- Simultaneous `flush` and `instr_ready` in HOLD: the flush takes priority. `pc_en` is 1 once, for the redirect.
- Timeout counter:
  - Counts consecutive REQ cycles and clears on entry to REQ.
  - When the count reaches `TIMEOUT` without an ack: `mem_req` drops, `bus_fault` is set, and the state goes to FAULT.
  - A `mem_ack` that arrives in the same cycle as the limit wins, and no fault is raised.
- Reset asserted mid-REQ: everything clears immediately. The memory is required to tolerate a request being abandoned.

## Timing
- Sequence after `reset` releases (cycles counted from that edge):
  - Cycle 0: IDLE.
  - Cycle 1: REQ.
  - `instr_valid` rises on the edge after `mem_ack`.
- Zero-wait memory: one instruction per 3 cycles (IDLE, REQ, HOLD), with `instr_ready` held high.
- Each additional memory wait state adds one cycle.
- `pc_en` and the IDLE entry coincide on one edge, so IDLE always samples the updated PC.

## Configuration
- **`FETCH_ALIGN_CHECK_EN` defined:** in IDLE, if `pc[1:0] != 0`:
  - no request is issued;
  - `misalign` is set;
  - the state goes to FAULT.
- **`FETCH_ALIGN_CHECK_EN` undefined:**
  - the `misalign` port is absent;
  - `pc[1:0]` is ignored, and the fetch is from `{pc[31:2],2'b00}`.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum: IDLE, REQ, HOLD, FAULT.
  - `FETCH_NOP` constant, the default for `NOP_INSTR`.
- One sub-module, `fetch_timeout_counter`:
  - parameter `TIMEOUT`;
  - inputs `clear` and `count`;
  - output `expired`;
  - tied off to 0 when `TIMEOUT = 0`.

## Test plan
- **Reset and zero-wait fetch:** reset, `pc`=0, `mem_ack` held 1, `mem_rdata`=0x00500093 -> `mem_req` in cycle 1, `instr_valid` in cycle 2, `instr`=0x00500093, `instr_pc`=0, `pc_en`=1 in cycle 2.
- **Wait states:** `mem_ack` delayed 3 cycles, `pc`=0x40 -> `mem_req` high for 4 cycles, `mem_addr`=0x40 throughout, one HOLD.
- **Backpressure:** `instr_ready`=0 for 5 cycles -> `instr_valid`=1 and `instr` stable, `pc_en`=0, no new `mem_req`.
- **Flush in REQ:** flush in REQ cycle 1, ack in cycle 3 with 0xDEADBEEF -> `pc_en`=1 on the flush cycle only, 0xDEADBEEF never valid, the next request uses the new `pc`.
- **Timeout:** `TIMEOUT`=4, no ack -> `mem_req` drops after 4 cycles, `bus_fault`=1 until flush, then fetching resumes.
- **Alignment (macro defined):** `pc`=0x102 -> `misalign`=1, `mem_req` never rises; flush clears the flag.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction bus and decode handshake bundle of the fetch sequencer
interface fetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - counts consecutive request cycles, flags the timeout limit
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset, clear, count};
            assign expired = 1'b0;
        end else begin : g_cnt
            localparam int W = $clog2(TIMEOUT + 1);
            logic [W-1:0] cnt;

            // expired is asserted during the TIMEOUT-th counted cycle itself
            assign expired = count && (cnt == W'(TIMEOUT - 1));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (count && !expired) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer; FETCH_ALIGN_CHECK_EN adds the misaligned-PC fault
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = FETCH_NOP,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_en,
    input  logic        flush,
    fetch_if.master     bus,
    output logic        bus_fault
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  addr_q, addr_nxt;
    logic [31:0]  instr_q, instr_nxt;
    logic [31:0]  ipc_q, ipc_nxt;
    logic         discard_q, discard_nxt;
    logic         fault_q, fault_nxt;
    logic         expired;
    logic         instr_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         mis_q, mis_nxt;
`endif

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != REQ),
        .count   (state == REQ),
        .expired (expired)
    );

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        instr_nxt   = instr_q;
        ipc_nxt     = ipc_q;
        discard_nxt = discard_q;
        fault_nxt   = fault_q;
`ifdef FETCH_ALIGN_CHECK_EN
        mis_nxt     = mis_q;
`endif
        case (state)
            IDLE: begin
                // a redirect in IDLE delays the PC sample by one cycle so the new target is seen
                if (!flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        mis_nxt   = 1'b1;
                        state_nxt = FAULT;
                    end else begin
                        addr_nxt  = word_align(pc);
                        state_nxt = REQ;
                    end
`else
                    addr_nxt  = word_align(pc);
                    state_nxt = REQ;
`endif
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    if (discard_q || flush) begin
                        discard_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        instr_nxt = bus.mem_rdata;
                        ipc_nxt   = addr_q;
                        state_nxt = HOLD;
                    end
                end else if (expired) begin
                    fault_nxt   = 1'b1;
                    discard_nxt = 1'b0;
                    state_nxt   = FAULT;
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    instr_nxt = NOP_INSTR;
                    state_nxt = IDLE;
                end else if (bus.instr_ready) begin
                    state_nxt = IDLE;
                end
            end
            FAULT: begin
                if (flush) begin
                    fault_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    mis_nxt   = 1'b0;
`endif
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            instr_q   <= NOP_INSTR;
            ipc_q     <= '0;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            instr_q   <= instr_nxt;
            ipc_q     <= ipc_nxt;
            discard_q <= discard_nxt;
            fault_q   <= fault_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q     <= mis_nxt;
`endif
        end
    end

    assign instr_valid     = (state == HOLD);
    assign bus.instr_valid = instr_valid;
    assign bus.mem_req     = (state == REQ);
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign bus_fault       = fault_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign        = mis_q;
`endif

    // PC moves on a redirect or an accepted instruction; held off while in reset
    assign pc_en = reset & (flush | (instr_valid & bus.instr_ready));

endmodule
